// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset sequencing blocks.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    SEQ_RESET   = 2'd0,
    SEQ_HOLD    = 2'd1,
    SEQ_RELEASE = 2'd2,
    SEQ_DONE    = 2'd3
  } clk_rst_seq_state_e;

  // Width of a counter that must reach the larger of the hold and stagger terminal counts.
  function automatic int unsigned seq_cnt_width(input int unsigned hold_cycles,
                                                input int unsigned stagger_cycles);
    int unsigned max_cycles;
    max_cycles = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clock edge.
// rst_rel_o flags that the output is dropping on the coming edge, so a consumer can act
// on the same edge the synchronized reset falls instead of one edge later.
module clk_rst_sync (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_sync_o,
  output logic rst_rel_o
);

  logic meta_q;
  logic sync_q;

  // Async assert of both stages, zeros shifted in once the raw reset drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_o = sync_q;
  assign rst_rel_o  = ~meta_q;

endmodule

// File: rtl/clk_rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets after reset release, then lets them go one
// at a time in index order. A software request restarts the hold from any active state.
//
//  state       | meaning
//  SEQ_RESET   | top-level reset asserted or still synchronizing; all outputs held
//  SEQ_HOLD    | all resets held, counting the hold time
//  SEQ_RELEASE | releasing resets one per stagger period
//  SEQ_DONE    | every reset released; waits for a software re-reset
module clk_rst_seq_ctrl
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUMBER_OF_RSTS = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sw_rst_req,
  output logic [NUMBER_OF_RSTS-1:0] rst_out,
  output logic [NUMBER_OF_RSTS-1:0] rst_n_out,
  output logic                      seq_busy,
  output logic                      seq_done
);

  localparam int unsigned CNT_W = seq_cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
  localparam int unsigned IDX_W = $clog2(NUMBER_OF_RSTS + 1);

  clk_rst_seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUMBER_OF_RSTS-1:0] rst_out_q, rst_out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      rst_sync;
  logic                      rst_rel;

  clk_rst_sync u_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .rst_sync_o (rst_sync),
    .rst_rel_o  (rst_rel)
  );

  // State, counter, index and registered outputs; the raw reset forces them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEQ_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: hold timer, staggered release, software re-reset override.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;

    case (state_q)
      SEQ_RESET: begin
        rst_out_d = '1;
        // Leave on the edge the synchronized reset drops so timing counts from that edge.
        if (rst_rel || !rst_sync) begin
          state_d = SEQ_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SEQ_HOLD: begin
        rst_out_d = '1;
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          rst_out_d[0] = 1'b0;
          idx_d        = IDX_W'(1);
          cnt_d        = '0;
          state_d      = (NUMBER_OF_RSTS == 1) ? SEQ_DONE : SEQ_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          for (int i = 0; i < int'(NUMBER_OF_RSTS); i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_out_d[i] = 1'b0;
            end
          end
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUMBER_OF_RSTS - 1)) begin
            state_d = SEQ_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_DONE: begin
        rst_out_d = '0;
      end
      default: begin
        state_d   = SEQ_RESET;
        rst_out_d = '1;
      end
    endcase

    // A software request beats any release happening on the same edge.
    if (sw_rst_req && (state_q != SEQ_RESET)) begin
      state_d   = SEQ_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
    end
  end

  // Status flags follow the state being entered so they line up with rst_out.
  always_comb begin
    busy_d = (state_d == SEQ_HOLD) || (state_d == SEQ_RELEASE);
    done_d = (state_d == SEQ_DONE);
  end

  assign rst_out   = rst_out_q;
  assign rst_n_out = ~rst_out_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;

endmodule
